// File: rtl/uart_frame_pkg.sv
// -----------------------------------------------------------------------------
// uart_frame_pkg
// Shared definitions for the UART receive framing controller:
//   - state_t     : FSM state encoding (also exported on the debug state port)
//   - calc_*      : elaboration-time helpers that derive bit time, inter-byte
//                   timeout and counter/index widths from the top parameters
// -----------------------------------------------------------------------------
package uart_frame_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEN   = 3'd1,
      S_PAY   = 3'd2,
      S_CSUM  = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   // Clocks per UART bit (integer division, truncates).
   function automatic int calc_bit_clks(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

   // Inter-byte timeout expressed in system clocks.
   function automatic int calc_timeout_clks(input int clk_freq, input int baud_rate,
                                            input int timeout_bits);
      return timeout_bits * calc_bit_clks(clk_freq, baud_rate);
   endfunction

   // Width of a counter that must hold 0..timeout_clks-1.
   function automatic int calc_cnt_width(input int timeout_clks);
      return (timeout_clks > 1) ? $clog2(timeout_clks) : 1;
   endfunction

   // Width of an index into a max_len-entry buffer.
   function automatic int calc_idx_width(input int max_len);
      return (max_len > 1) ? $clog2(max_len) : 1;
   endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// -----------------------------------------------------------------------------
// uart_frame_buf
// Single-payload storage for the framing controller. MAX_LEN x 8 register
// array written from the receive side; the drain side walks it with a
// registered read index.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en             write wr_data at wr_idx this cycle
//   wr_idx, wr_data   write address / data
//   rd_clr            force read index back to entry 0
//   rd_adv            step read index to the next entry
//   rd_idx            current read index
//   rd_data           entry at rd_idx (combinational from registers)
// -----------------------------------------------------------------------------
module uart_frame_buf
   import uart_frame_pkg::*;
#(
   parameter int MAX_LEN = 16,
   parameter int IDX_W   = calc_idx_width(MAX_LEN)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_clr,
   input  logic              rd_adv,
   output logic [IDX_W-1:0]  rd_idx,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [MAX_LEN];

   // NOTE: the storage array is deliberately not reset; entries are always
   // written before the drain side can read them, and leaving reset off lets
   // the array map onto plain flops/RAM without a reset tree.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= wr_data;
   end

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      rd_idx <= '0;
      else if (rd_clr) rd_idx <= '0;
      else if (rd_adv) rd_idx <= rd_idx + IDX_W'(1);
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_ctrl
// Turns the byte stream of a one-byte UART receiver into framed packets:
//   HDR_BYTE, LEN, LEN payload bytes [, checksum]
// Validates length, inter-byte timeout and (optionally) checksum, buffers one
// payload and drains it on a valid/ready byte stream.
//
// Build option: define UART_FRAME_CSUM_EN to expect a checksum byte after the
// payload (checksum = LEN + sum(payload) mod 256). Undefined: no checksum byte,
// err_csum tied low.
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   en             controller enable; low aborts any frame silently
//   rx_data        received byte, valid with rx_done
//   rx_done        one-cycle pulse per received byte
//   rx_en          receiver enable (off while draining)
//   m_data         payload byte out
//   m_valid        payload byte valid
//   m_last         final payload byte of the frame
//   m_ready        consumer accept
//   busy           FSM not idle
//   err_len        pulse: LEN==0 or LEN>MAX_LEN
//   err_timeout    pulse: inter-byte gap expired
//   err_csum       pulse: checksum mismatch
//   frame_cnt      frames fully drained (wraps)
//   state          current FSM state (debug)
// -----------------------------------------------------------------------------
module uart_rx_frame_ctrl
   import uart_frame_pkg::*;
#(
   parameter int         CLK_FREQ     = 50_000_000,
   parameter int         BAUD_RATE    = 115200,
   parameter logic [7:0] HDR_BYTE     = 8'hA5,
   parameter int         MAX_LEN      = 16,
   parameter int         TIMEOUT_BITS = 20
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [7:0]  rx_data,
   input  logic        rx_done,
   output logic        rx_en,
   output logic [7:0]  m_data,
   output logic        m_valid,
   output logic        m_last,
   input  logic        m_ready,
   output logic        busy,
   output logic        err_len,
   output logic        err_timeout,
   output logic        err_csum,
   output logic [15:0] frame_cnt,
   output logic [2:0]  state
);

   localparam int TIMEOUT_CLKS = calc_timeout_clks(CLK_FREQ, BAUD_RATE, TIMEOUT_BITS);
   localparam int CNT_W        = calc_cnt_width(TIMEOUT_CLKS);
   localparam int IDX_W        = calc_idx_width(MAX_LEN);

   localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CLKS - 1);
   localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

   state_t           cur_state;
   logic [7:0]       len;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;
   logic [7:0]       rd_data;
   logic [CNT_W-1:0] tmo_cnt;

   logic tmo_run, tmo_expired;
   logic buf_wr, rd_adv, rd_clr;
   logic wr_at_last, rd_at_last;

`ifdef UART_FRAME_CSUM_EN
   logic [7:0] csum;
`endif

   // Timeout only guards the receive phases; a byte in the expiry cycle wins.
   assign tmo_run     = (cur_state == S_LEN) || (cur_state == S_PAY) ||
                        (cur_state == S_CSUM);
   assign tmo_expired = tmo_run && !rx_done && (tmo_cnt == TMO_LAST);

   assign wr_at_last = (8'(wr_idx) == len - 8'd1);
   assign rd_at_last = (8'(rd_idx) == len - 8'd1);

   assign buf_wr = en && rx_done && (cur_state == S_PAY);
   assign rd_clr = (cur_state != S_DRAIN);
   assign rd_adv = en && m_valid && m_ready && !rd_at_last;

   assign rx_en  = en && (cur_state != S_DRAIN);
   assign busy   = (cur_state != S_IDLE);
   assign state  = cur_state;
   assign m_last = m_valid && rd_at_last;
   // Unwritten buffer entries are never exposed: data reads as zero when idle.
   assign m_data = m_valid ? rd_data : 8'h00;

   uart_frame_buf #(
      .MAX_LEN (MAX_LEN),
      .IDX_W   (IDX_W)
   ) u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (buf_wr),
      .wr_idx  (wr_idx),
      .wr_data (rx_data),
      .rd_clr  (rd_clr),
      .rd_adv  (rd_adv),
      .rd_idx  (rd_idx),
      .rd_data (rd_data)
   );

`ifndef UART_FRAME_CSUM_EN
   assign err_csum = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_state   <= S_IDLE;
         len         <= '0;
         wr_idx      <= '0;
         tmo_cnt     <= '0;
         m_valid     <= 1'b0;
         err_len     <= 1'b0;
         err_timeout <= 1'b0;
         frame_cnt   <= '0;
`ifdef UART_FRAME_CSUM_EN
         csum        <= '0;
         err_csum    <= 1'b0;
`endif
      end else begin
         // Error outputs are single-cycle pulses.
         err_len     <= 1'b0;
         err_timeout <= 1'b0;
`ifdef UART_FRAME_CSUM_EN
         err_csum    <= 1'b0;
`endif

         if (!tmo_run || rx_done || tmo_expired) tmo_cnt <= '0;
         else                                    tmo_cnt <= tmo_cnt + CNT_W'(1);

         if (!en) begin
            cur_state <= S_IDLE;
            m_valid   <= 1'b0;
         end else begin
            case (cur_state)
               S_IDLE: begin
                  if (rx_done && (rx_data == HDR_BYTE)) cur_state <= S_LEN;
               end

               S_LEN: begin
                  if (rx_done) begin
                     if ((rx_data == 8'd0) || (rx_data > MAX_LEN_B)) begin
                        err_len   <= 1'b1;
                        cur_state <= S_IDLE;
                     end else begin
                        len       <= rx_data;
                        wr_idx    <= '0;
`ifdef UART_FRAME_CSUM_EN
                        csum      <= rx_data;
`endif
                        cur_state <= S_PAY;
                     end
                  end else if (tmo_expired) begin
                     err_timeout <= 1'b1;
                     cur_state   <= S_IDLE;
                  end
               end

               S_PAY: begin
                  if (rx_done) begin
                     wr_idx <= wr_idx + IDX_W'(1);
`ifdef UART_FRAME_CSUM_EN
                     csum   <= csum + rx_data;
                     if (wr_at_last) cur_state <= S_CSUM;
`else
                     if (wr_at_last) begin
                        cur_state <= S_DRAIN;
                        m_valid   <= 1'b1;
                     end
`endif
                  end else if (tmo_expired) begin
                     err_timeout <= 1'b1;
                     cur_state   <= S_IDLE;
                  end
               end

`ifdef UART_FRAME_CSUM_EN
               S_CSUM: begin
                  if (rx_done) begin
                     if (rx_data == csum) begin
                        cur_state <= S_DRAIN;
                        m_valid   <= 1'b1;
                     end else begin
                        err_csum  <= 1'b1;
                        cur_state <= S_IDLE;
                     end
                  end else if (tmo_expired) begin
                     err_timeout <= 1'b1;
                     cur_state   <= S_IDLE;
                  end
               end
`endif

               S_DRAIN: begin
                  if (m_ready && rd_at_last) begin
                     m_valid   <= 1'b0;
                     frame_cnt <= frame_cnt + 16'd1;
                     cur_state <= S_IDLE;
                  end
               end

               default: begin
                  cur_state <= S_IDLE;
                  m_valid   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_frame_ctrl
// Scoreboard bench for uart_rx_frame_ctrl at default parameters. The stimulus
// side builds frames, decides from the framing rules what the consumer should
// receive (or which error should fire) and queues it; a monitor compares the
// drained stream, stall behaviour and error pulses independently.
// Honors UART_FRAME_CSUM_EN the same way the design does.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_frame_ctrl;

   localparam int         MAX_LEN      = 16;
   localparam int         TIMEOUT_CLKS = 20 * (50_000_000 / 115200);
   localparam logic [7:0] HDR          = 8'hA5;
`ifdef UART_FRAME_CSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_done = 1'b0;
   logic        m_ready = 1'b0;
   logic        rx_en, m_valid, m_last, busy;
   logic        err_len, err_timeout, err_csum;
   logic [7:0]  m_data;
   logic [15:0] frame_cnt;
   logic [2:0]  state;

   uart_rx_frame_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .rx_data     (rx_data),
      .rx_done     (rx_done),
      .rx_en       (rx_en),
      .m_data      (m_data),
      .m_valid     (m_valid),
      .m_last      (m_last),
      .m_ready     (m_ready),
      .busy        (busy),
      .err_len     (err_len),
      .err_timeout (err_timeout),
      .err_csum    (err_csum),
      .frame_cnt   (frame_cnt),
      .state       (state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic       last;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          exp_len_err = 0, exp_tmo_err = 0, exp_csum_err = 0;
   int          seen_len = 0, seen_tmo = 0, seen_csum = 0;
   int          exp_frames = 0;
   int unsigned cyc = 0;
   int unsigned last_rx_cyc = 0;
   int unsigned tmo_seen_cyc = 0;
   int          ready_mode = 0;
   logic [7:0]  pay[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, expv, $time);
      end
   endtask

   // Consumer: always ready, fixed 1,0,0 pattern, or random.
   initial begin
      int k = 0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       m_ready = 1'b1;
            1:       begin m_ready = (k % 3 == 0); k++; end
            default: m_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: scoreboard pops, stall stability, error pulse bookkeeping.
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data  = 8'h00;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (err_len)     seen_len++;
         if (err_csum)    seen_csum++;
         if (err_timeout) begin seen_tmo++; tmo_seen_cyc = cyc; end
         if (err_len | err_timeout | err_csum)
            check("err_onehot", 32'($countones({err_len, err_timeout, err_csum})), 1);
         if (m_valid) check("rx_en_in_drain", {31'd0, rx_en}, 0);
         if (prev_stall) begin
            check("stall_valid", {31'd0, m_valid}, 1);
            check("stall_data", {24'd0, m_data}, {24'd0, prev_data});
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_m_valid", {31'd0, m_valid}, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("m_data", {24'd0, m_data}, {24'd0, e.data});
               check("m_last", {31'd0, m_last}, {31'd0, e.last});
               if (e.last) exp_frames++;
            end
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
      end
   end

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      @(posedge clk);
      #1;
      last_rx_cyc = cyc;
      rx_done = 1'b0;
   endtask

   // Sends a frame and queues the outcome the framing rules predict.
   task automatic send_frame(input logic [7:0] len, input logic [7:0] bytes[$],
                             input bit bad_csum, input int max_gap);
      logic [7:0] sum;
      send_byte(HDR);
      idle($urandom_range(0, max_gap));
      send_byte(len);
      if (len == 8'd0 || len > 8'(MAX_LEN)) begin
         exp_len_err++;
         return;
      end
      sum = len;
      for (int i = 0; i < int'(len); i++) sum += bytes[i];
      if (CSUM_EN && bad_csum) begin
         exp_csum_err++;
      end else begin
         for (int i = 0; i < int'(len); i++) begin
            exp_t e;
            e.data = bytes[i];
            e.last = (i == int'(len) - 1);
            exp_q.push_back(e);
         end
      end
      for (int i = 0; i < int'(len); i++) begin
         idle($urandom_range(0, max_gap));
         send_byte(bytes[i]);
      end
      if (CSUM_EN) begin
         idle($urandom_range(0, max_gap));
         send_byte(bad_csum ? sum + 8'($urandom_range(1, 255)) : sum);
      end
   endtask

   task automatic wait_drain();
      int i = 0;
      while ((exp_q.size() != 0 || m_valid) && i < 1000) begin
         @(posedge clk);
         #1;
         i++;
      end
      check("drain_done", exp_q.size(), 0);
   endtask

   task automatic checkpoint(input string tag);
      wait_drain();
      idle(2);
      check({tag, "_state"}, {29'd0, state}, 0);
      check({tag, "_busy"}, {31'd0, busy}, 0);
      check({tag, "_frame_cnt"}, {16'd0, frame_cnt}, 32'(exp_frames));
      check({tag, "_err_len"}, seen_len, exp_len_err);
      check({tag, "_err_tmo"}, seen_tmo, exp_tmo_err);
      check({tag, "_err_csum"}, seen_csum, exp_csum_err);
   endtask

   task automatic fill_pay(input int n);
      pay.delete();
      for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
   endtask

   initial begin
      // Reset state
      #12;
      check("rst_rx_en", {31'd0, rx_en}, 0);
      check("rst_m_data", {24'd0, m_data}, 0);
      check("rst_m_valid", {31'd0, m_valid}, 0);
      check("rst_m_last", {31'd0, m_last}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_errs", {29'd0, err_len, err_timeout, err_csum}, 0);
      check("rst_frame_cnt", {16'd0, frame_cnt}, 0);
      check("rst_state", {29'd0, state}, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      en    = 1'b1;
      idle(2);
      check("rx_en_idle", {31'd0, rx_en}, 1);

      // Reference frame, consumer always ready
      ready_mode = 0;
      pay = {8'h11, 8'h22, 8'h33};
      send_frame(8'd3, pay, 1'b0, 0);
      checkpoint("basic");

      // Same frame, consumer pattern 1,0,0,...
      ready_mode = 1;
      send_frame(8'd3, pay, 1'b0, 0);
      checkpoint("stall");

      // Bad checksum, then a good frame
      ready_mode = 0;
      send_frame(8'd3, pay, 1'b1, 0);
      checkpoint("bad_csum");
      send_frame(8'd3, pay, 1'b0, 0);
      checkpoint("after_csum");

      // Length errors
      send_frame(8'd0, pay, 1'b0, 0);
      checkpoint("len0");
      send_frame(8'd17, pay, 1'b0, 0);
      checkpoint("len17");
      fill_pay(MAX_LEN);
      send_frame(8'(MAX_LEN), pay, 1'b0, 1);
      checkpoint("len_max");

      // Inter-byte timeout after A5 03 11
      send_byte(HDR);
      send_byte(8'd3);
      send_byte(8'h11);
      exp_tmo_err++;
      tmo_seen_cyc = 0;
      idle(9000);
      check("tmo_latency", tmo_seen_cyc - last_rx_cyc, TIMEOUT_CLKS);
      checkpoint("timeout");
      pay = {8'h11, 8'h22, 8'h33};
      send_frame(8'd3, pay, 1'b0, 0);
      checkpoint("after_tmo");

      // Noise in idle is ignored
      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'h5A);
      checkpoint("noise");

      // en dropped mid-payload
      send_byte(HDR);
      send_byte(8'd3);
      send_byte(8'h11);
      check("pay_state", {29'd0, state}, 2);
      en = 1'b0;
      @(posedge clk);
      #1;
      check("en_drop_state", {29'd0, state}, 0);
      check("en_drop_valid", {31'd0, m_valid}, 0);
      check("en_drop_rx_en", {31'd0, rx_en}, 0);
      en = 1'b1;
      checkpoint("en_drop");

      // Randomized frames
      for (int n = 0; n < 25; n++) begin
         logic [7:0] len;
         ready_mode = $urandom_range(0, 2);
         if ($urandom_range(0, 3) == 0) begin
            logic [7:0] noise;
            do noise = 8'($urandom); while (noise == HDR);
            send_byte(noise);
         end
         case ($urandom_range(0, 9))
            0:       len = 8'd0;
            1:       len = 8'($urandom_range(MAX_LEN + 1, 255));
            default: len = 8'($urandom_range(1, MAX_LEN));
         endcase
         fill_pay(MAX_LEN);
         send_frame(len, pay, ($urandom_range(0, 4) == 0), 3);
         checkpoint("rand");
      end

      // Asynchronous reset mid-frame
      ready_mode = 0;
      send_byte(HDR);
      send_byte(8'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_state", {29'd0, state}, 0);
      check("arst_busy", {31'd0, busy}, 0);
      check("arst_frame_cnt", {16'd0, frame_cnt}, 0);
      exp_frames = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(2);
      pay = {8'h11, 8'h22, 8'h33};
      send_frame(8'd3, pay, 1'b0, 0);
      checkpoint("post_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
